// File: rtl/exe_pipe_ctrl_if.sv
// Execute-stage sequencing bus: hazard inputs from ID/EXE/LSU and the
// stall, flush and redirect controls returned to the pipeline.
interface exe_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_is_load;
  logic             ex_reg_write;
  logic [4:0]       ex_wr_addr;
  logic             ex_resolve_valid;
  logic             ex_taken;
  logic             ex_pred_taken;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_target;
  logic             lsu_busy;
  logic             exe_wait;
  logic             id_stall;
  logic             flush_if;
  logic             flush_id;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [1:0]       state;
  logic [CNT_W-1:0] mispredict_cnt;

  // Pipeline side: presents hazard information, consumes controls
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_is_load, ex_reg_write, ex_wr_addr,
           ex_resolve_valid, ex_taken, ex_pred_taken, ex_pc, ex_target,
           lsu_busy,
    input  exe_wait, id_stall, flush_if, flush_id,
           redirect_valid, redirect_pc, state, mispredict_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_is_load, ex_reg_write, ex_wr_addr,
           ex_resolve_valid, ex_taken, ex_pred_taken, ex_pc, ex_target,
           lsu_busy,
    output exe_wait, id_stall, flush_if, flush_id,
           redirect_valid, redirect_pc, state, mispredict_cnt
  );
endinterface

// File: rtl/exe_pipe_ctrl.sv
// Execute-stage pipeline sequencing controller. Chooses between advance,
// hold (load-use or LSU busy) and flush (branch mispredict) every cycle.
// All outputs come straight from flops.
module exe_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           rstn,
  exe_pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic             exe_wait_q, exe_wait_d;
  logic             id_stall_q, id_stall_d;
  logic             flush_q, flush_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mispredict;
  logic             loaduse;
  logic             rs1_hit;
  logic             rs2_hit;
  logic [2:0]       flush_cnt_dec;

  // Hazard detection; a write to x0 never produces a dependency
  always_comb begin
    mispredict = bus.ex_resolve_valid & (bus.ex_taken != bus.ex_pred_taken);
    rs1_hit    = bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_wr_addr);
    rs2_hit    = bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_wr_addr);
    loaduse    = bus.id_valid & bus.ex_is_load & bus.ex_reg_write &
                 (bus.ex_wr_addr != 5'd0) & (rs1_hit | rs2_hit);
    flush_cnt_dec = flush_cnt_q - 3'd1;
  end

  // Next-state and next-output decision; strobes default low each cycle
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    exe_wait_d    = 1'b0;
    id_stall_d    = 1'b0;
    flush_d       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d       = FLUSH;
          redirect_d    = 1'b1;
          redirect_pc_d = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
          flush_cnt_d   = FLUSH_INIT;
          flush_d       = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (bus.lsu_busy) begin
          state_d    = MEM_WAIT;
          exe_wait_d = 1'b1;
          id_stall_d = 1'b1;
        end else if (loaduse) begin
          state_d    = LU_STALL;
          exe_wait_d = 1'b1;
          id_stall_d = 1'b1;
        end
      end
      LU_STALL: begin
        if (bus.lsu_busy) begin
          state_d    = MEM_WAIT;
          exe_wait_d = 1'b1;
          id_stall_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_dec;
        if (flush_cnt_dec == 3'd0) state_d = RUN;
        else                       flush_d = 1'b1;
      end
      MEM_WAIT: begin
        if (bus.lsu_busy) begin
          exe_wait_d = 1'b1;
          id_stall_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= RUN;
      flush_cnt_q   <= 3'd0;
      exe_wait_q    <= 1'b0;
      id_stall_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      exe_wait_q    <= exe_wait_d;
      id_stall_q    <= id_stall_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.exe_wait       = exe_wait_q;
  assign bus.id_stall       = id_stall_q;
  assign bus.flush_if       = flush_q;
  assign bus.flush_id       = flush_q;
  assign bus.redirect_valid = redirect_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.state          = state_q;
  assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Self-checking bench for exe_pipe_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_exe_pipe_ctrl;

  localparam int FC      = 2;
  localparam int CW      = 2;
  localparam int CNT_TOP = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn;

  exe_pipe_ctrl_if #(.CNT_W(CW)) bus ();

  exe_pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Model of the controller: which mode the pipe is in and the values
  // each output should show after the current edge.
  int          mMode;
  int          cycleNo;
  int          flushStart;
  bit          mWait;
  bit          mFlush;
  bit          mRedirect;
  logic [31:0] mPc;
  int          mCnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNo);
    end
  endtask

  task automatic setIdle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_is_load = 0; bus.ex_reg_write = 0; bus.ex_wr_addr = 0;
    bus.ex_resolve_valid = 0; bus.ex_taken = 0; bus.ex_pred_taken = 0;
    bus.ex_pc = 0; bus.ex_target = 0; bus.lsu_busy = 0;
  endtask

  task automatic applyStimulus();
    bus.id_valid         = 1'($urandom_range(0, 1));
    bus.id_rs1           = 5'($urandom_range(0, 3));
    bus.id_rs2           = 5'($urandom_range(0, 3));
    bus.id_uses_rs1      = 1'($urandom_range(0, 1));
    bus.id_uses_rs2      = 1'($urandom_range(0, 1));
    bus.ex_is_load       = 1'($urandom_range(0, 1));
    bus.ex_reg_write     = 1'($urandom_range(0, 3) != 0);
    bus.ex_wr_addr       = 5'($urandom_range(0, 3));
    bus.ex_resolve_valid = ($urandom_range(0, 3) == 0);
    bus.ex_taken         = 1'($urandom_range(0, 1));
    bus.ex_pred_taken    = 1'($urandom_range(0, 1));
    bus.ex_pc            = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    bus.ex_target        = $urandom();
    bus.lsu_busy         = ($urandom_range(0, 4) == 0);
  endtask

  // Apply the rules of the controller to the inputs seen at this edge
  task automatic modelStep();
    bit mp, lu;
    cycleNo++;
    mp = bus.ex_resolve_valid && (bus.ex_taken != bus.ex_pred_taken);
    lu = bus.id_valid && bus.ex_is_load && bus.ex_reg_write && (bus.ex_wr_addr != 0) &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_wr_addr) ||
          (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_wr_addr));
    mRedirect = 0;
    if (!rstn) begin
      mMode = 0; mWait = 0; mFlush = 0; mPc = 0; mCnt = 0;
      return;
    end
    case (mMode)
      0: begin
        if (mp) begin
          mMode = 2; mWait = 0; mFlush = 1; mRedirect = 1;
          flushStart = cycleNo;
          mPc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
          mCnt = (mCnt < CNT_TOP) ? mCnt + 1 : CNT_TOP;
        end else if (bus.lsu_busy) begin
          mMode = 3; mWait = 1;
        end else if (lu) begin
          mMode = 1; mWait = 1;
        end else begin
          mWait = 0;
        end
      end
      1: begin
        mMode = bus.lsu_busy ? 3 : 0;
        mWait = bus.lsu_busy;
      end
      2: begin
        if (cycleNo - flushStart >= FC) begin
          mMode = 0; mFlush = 0;
        end
      end
      default: begin
        mMode = bus.lsu_busy ? 3 : 0;
        mWait = bus.lsu_busy;
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("state",          32'(bus.state),          32'(mMode));
    checkOutput("exe_wait",       32'(bus.exe_wait),       32'(mWait));
    checkOutput("id_stall",       32'(bus.id_stall),       32'(mWait));
    checkOutput("flush_if",       32'(bus.flush_if),       32'(mFlush));
    checkOutput("flush_id",       32'(bus.flush_id),       32'(mFlush));
    checkOutput("redirect_valid", 32'(bus.redirect_valid), 32'(mRedirect));
    checkOutput("redirect_pc",    bus.redirect_pc,         mPc);
    checkOutput("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(mCnt));
    checkOutput("no_redir_wait",  32'(bus.redirect_valid & bus.exe_wait), 32'd0);
    checkOutput("no_flush_stall", 32'(bus.flush_if & bus.id_stall),      32'd0);
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle
  task automatic step();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic mispredict(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
    setIdle();
    bus.ex_resolve_valid = 1; bus.ex_taken = taken; bus.ex_pred_taken = ~taken;
    bus.ex_pc = pc; bus.ex_target = tgt;
  endtask

  int waitCycles;

  initial begin
    cycleNo = 0; flushStart = 0; mMode = 0; mWait = 0; mFlush = 0;
    mRedirect = 0; mPc = 0; mCnt = 0;
    rstn = 0;
    setIdle();
    @(negedge clk);

    // Reset held with inputs toggling
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      step();
    end
    checkOutput("reset_state", 32'(bus.state), 32'd0);
    rstn = 1;
    setIdle();
    step();

    // Load-use on rs2, then the same with x0 as destination
    bus.ex_is_load = 1; bus.ex_reg_write = 1; bus.ex_wr_addr = 5;
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = 5;
    step();
    checkOutput("lu_wait", 32'(bus.exe_wait), 32'd1);
    setIdle();
    step();
    checkOutput("lu_release", 32'(bus.exe_wait), 32'd0);
    bus.ex_is_load = 1; bus.ex_reg_write = 1; bus.ex_wr_addr = 0;
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = 0;
    step();
    checkOutput("lu_x0", 32'(bus.exe_wait), 32'd0);

    // Not-taken mispredict, then a correctly predicted branch
    mispredict(1'b0, 32'h100, 32'h500);
    step();
    checkOutput("nt_redirect_pc", bus.redirect_pc, 32'h104);
    checkOutput("nt_cnt", 32'(bus.mispredict_cnt), 32'd1);
    setIdle();
    step();
    step();
    checkOutput("flush_done", 32'(bus.flush_if), 32'd0);
    bus.ex_resolve_valid = 1; bus.ex_taken = 1; bus.ex_pred_taken = 1;
    step();
    checkOutput("good_pred", 32'(bus.redirect_valid), 32'd0);

    // Taken mispredict, and the PC+4 wrap case
    mispredict(1'b1, 32'h40, 32'h2000);
    step();
    checkOutput("tk_redirect_pc", bus.redirect_pc, 32'h2000);
    setIdle(); step(); step();
    mispredict(1'b0, 32'hFFFF_FFFC, 32'h0);
    step();
    checkOutput("wrap_redirect_pc", bus.redirect_pc, 32'h0);
    setIdle(); step(); step();

    // Mispredict together with lsu_busy; busy held through the flush
    mispredict(1'b0, 32'h200, 32'h0);
    bus.lsu_busy = 1;
    step();
    checkOutput("prio_flush", 32'(bus.state), 32'd2);
    bus.ex_resolve_valid = 0;
    step();
    step();
    checkOutput("flush_then_run", 32'(bus.state), 32'd0);
    step();
    checkOutput("run_then_memwait", 32'(bus.state), 32'd3);
    setIdle();
    step();

    // lsu_busy for 4 cycles gives exactly 4 cycles of exe_wait
    waitCycles = 0;
    for (int i = 0; i < 7; i++) begin
      bus.lsu_busy = (i < 4);
      step();
      if (bus.exe_wait) waitCycles++;
    end
    checkOutput("memwait_len", 32'(waitCycles), 32'd4);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 2; i++) begin
      mispredict(1'b1, 32'h0, 32'h80);
      step();
      setIdle(); step(); step();
    end
    checkOutput("cnt_saturated", 32'(bus.mispredict_cnt), 32'd3);

    // Reset during the first flush cycle
    mispredict(1'b1, 32'h0, 32'h300);
    step();
    rstn = 0;
    setIdle();
    step();
    checkOutput("rst_flush", 32'(bus.flush_if), 32'd0);
    checkOutput("rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
    rstn = 1;
    step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      rstn = ($urandom_range(0, 60) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
